uibi_arbiter: RTL
=================

UIBI_ARBITER -- requirements
Module: uibi_arbiter

Interface
REQ-001 Parameter NM, default 2: number of upstream masters (legal 1..8).
REQ-002 Parameter XLEN, default 32: address and data width.
REQ-003 Parameter NUM_W, default 4: bus_num width.
REQ-004 Parameter TIMEOUT, default 255: BUSY-cycle limit (legal 0..65535); 0 disables timeout.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 m_req  in  NM  per-master request; held high until that master's m_ready.
REQ-009 m_wen  in  NM  per-master write enable.
REQ-010 m_mode  in  3*NM  per-master access mode; slice i = bits [3i+2:3i].
REQ-011 m_addr  in  XLEN*NM  per-master address.
REQ-012 m_num  in  NUM_W*NM  per-master target device number.
REQ-013 m_dat_w  in  XLEN*NM  per-master write data.
REQ-014 m_ready  out  NM  per-master completion pulse, one cycle.
REQ-015 m_err  out  1  qualifies m_ready: transaction ended by timeout.
REQ-016 m_dat_r  out  XLEN  read data, shared by all masters; valid only with m_ready.
REQ-017 bus_req, bus_wen  out  1 each  UIBI master request and write enable.
REQ-018 bus_mode  out  3; bus_addr  out  XLEN; bus_num  out  NUM_W; bus_dat_o  out  XLEN  UIBI request fields.
REQ-019 bus_dat_i  in  XLEN; bus_ready  in  1  UIBI read data and completion.
REQ-020 grant  out  $clog2(NM) (min 1)  index of current/last granted master.

Function
REQ-021 FSM states: IDLE, BUSY.
REQ-022 IDLE: bus_req=0, all bus field outputs 0, m_ready=0.
REQ-023 IDLE with any m_req bit set: winner = first set bit scanning round-robin from (ptr+1) mod NM upward with wrap; grant<=winner, timer<=0, state<=BUSY at next edge.
REQ-024 Request-to-bus latency: exactly 1 cycle (m_req seen in IDLE at edge k -> bus_req=1 in cycle k+1).
REQ-025 BUSY: bus_req=1; bus_wen/mode/addr/num/dat_o combinationally equal slice[grant] of master inputs.
REQ-026 BUSY and bus_ready=1: same cycle m_ready[grant]=1, m_dat_r=bus_dat_i, m_err=0; next edge ptr<=grant, state<=IDLE.
REQ-027 Minimum one IDLE cycle between transactions; back-to-back grant impossible.
REQ-028 Non-granted masters see m_ready=0 always; their requests remain pending, never dropped.
REQ-029 BUSY, TIMEOUT!=0, bus_ready=0: timer increments each cycle (16 bit, saturating).
REQ-030 Timer == TIMEOUT-1 with bus_ready=0: that cycle m_ready[grant]=1, m_err=1, m_dat_r=all ones; bus_req remains 1 that cycle; next edge ptr<=grant, state<=IDLE.
REQ-031 bus_ready and timeout in same cycle: bus_ready wins, m_err=0.
REQ-032 Granted master deasserts m_req in BUSY (protocol violation): bus_req drops same cycle, no m_ready, next edge state<=IDLE, ptr<=grant.
REQ-033 bus_ready while IDLE: ignored, no m_ready.
REQ-034 NM=1: degenerates to a pass-through with 1-cycle request latency; grant constant 0.
REQ-035 Outside completion cycles m_dat_r=0 and m_err=0.

Reset
REQ-036 rst=1 at an edge: state<=IDLE, grant<=0, ptr<=NM-1 (master 0 has first priority), timer<=0.
REQ-037 Reset during BUSY aborts the transaction silently: no m_ready, bus_req=0 from cycle after reset edge.
REQ-038 During and immediately after reset all outputs are 0.

Verification
REQ-039 NM=2; m_req=2'b11 from reset, bus_ready 2 cycles after each bus_req -> master 0 served first, then master 1, then 0 again; grant sequence 0,1,0.
REQ-040 Master 1 read addr 0x100, bus_dat_i=0xDEADBEEF with bus_ready -> m_ready=2'b10, m_dat_r=0xDEADBEEF, m_err=0 same cycle.
REQ-041 TIMEOUT=4, bus_ready never asserted -> m_ready[grant] and m_err high on 4th BUSY cycle, m_dat_r=0xFFFFFFFF, then IDLE.
REQ-042 NM=4, only m_req[3] and m_req[1] set, ptr=1 -> master 3 granted, then master 1 (wrap).
REQ-043 rst asserted in 2nd BUSY cycle -> no m_ready, bus_req=0 next cycle, next grant goes to master 0.
REQ-044 bus_ready and timer==TIMEOUT-1 coincide -> m_err=0, m_dat_r=bus_dat_i.

Source files
------------

// File: rtl/uibi_arbiter.sv
// rtl/uibi_arbiter.sv - round-robin arbiter of NM upstream masters onto one UIBI master port
module uibi_arbiter #(
  parameter int NM      = 2,
  parameter int XLEN    = 32,
  parameter int NUM_W   = 4,
  parameter int TIMEOUT = 255,
  localparam int GW     = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NM-1:0]          m_req,
  input  logic [NM-1:0]          m_wen,
  input  logic [3*NM-1:0]        m_mode,
  input  logic [XLEN*NM-1:0]     m_addr,
  input  logic [NUM_W*NM-1:0]    m_num,
  input  logic [XLEN*NM-1:0]     m_dat_w,
  output logic [NM-1:0]          m_ready,
  output logic                   m_err,
  output logic [XLEN-1:0]        m_dat_r,
  output logic                   bus_req,
  output logic                   bus_wen,
  output logic [2:0]             bus_mode,
  output logic [XLEN-1:0]        bus_addr,
  output logic [NUM_W-1:0]       bus_num,
  output logic [XLEN-1:0]        bus_dat_o,
  input  logic [XLEN-1:0]        bus_dat_i,
  input  logic                   bus_ready,
  output logic [GW-1:0]          grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Timer compare value; a TIMEOUT of zero never fires.
  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0]   TO_LAST = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   winner;
  logic            found;
  logic [15:0]     timer;

  logic            busy;
  logic            gnt_req;
  logic            done_ok;
  logic            time_out;
  logic            finish;

  // Reset masks the bus side immediately so an aborted transfer never completes.
  assign busy     = (state == BUSY) && !rst;
  assign gnt_req  = m_req[grant_q];
  assign bus_req  = busy && gnt_req;
  assign done_ok  = bus_req && bus_ready;
  assign time_out = TO_EN && bus_req && !bus_ready && (timer == TO_LAST);
  assign finish   = done_ok || time_out;
  assign grant    = rst ? '0 : grant_q;

  // Round-robin search: first requester after the last served master, wrapping.
  always_comb begin
    int idx;
    winner = ptr;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NM; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NM) idx = idx - NM;
      if (!found && m_req[idx]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Forward the granted master's request fields; all zero whenever no request is on the bus.
  always_comb begin
    bus_wen   = 1'b0;
    bus_mode  = '0;
    bus_addr  = '0;
    bus_num   = '0;
    bus_dat_o = '0;
    if (bus_req) begin
      bus_wen   = m_wen[grant_q];
      bus_mode  = m_mode[3*int'(grant_q) +: 3];
      bus_addr  = m_addr[XLEN*int'(grant_q) +: XLEN];
      bus_num   = m_num[NUM_W*int'(grant_q) +: NUM_W];
      bus_dat_o = m_dat_w[XLEN*int'(grant_q) +: XLEN];
    end
  end

  // Completion pulse to the granted master; a real bus_ready beats a coincident timeout.
  always_comb begin
    m_ready = '0;
    m_err   = 1'b0;
    m_dat_r = '0;
    if (finish) begin
      m_ready[grant_q] = 1'b1;
      m_err            = time_out;
      m_dat_r          = done_ok ? bus_dat_i : '1;
    end
  end

  // Arbitration FSM: grant in IDLE, release on completion, timeout or dropped request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr     <= GW'(NM - 1);
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= winner;
            timer   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!gnt_req || finish) begin
            ptr   <= grant_q;
            state <= IDLE;
          end else if (TO_EN && timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
